// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline register with valid/ready handshake and split decode fields.
// Build option IF_ID_SKID_EN adds a skid register so if_ready is registered (no id_ready path).
module if_id_stage #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [15:0]     if_instr,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_ready,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [15:0]     id_instr,
    output logic [PC_W-1:0] id_pc,
    output logic [3:0]      id_opcode,
    output logic [7:0]      id_imm8
);

`ifdef IF_ID_SKID_EN
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;
`else
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_ONE   = 1'b1
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            accept;
    logic            deliver;

`ifdef IF_ID_SKID_EN
    logic [15:0]     skid_instr_q, skid_instr_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic            rdy_q, rdy_d;

    assign if_ready = rdy_q;
`else
    assign if_ready = !id_valid || id_ready;
`endif

    assign id_valid  = (state_q != S_EMPTY);
    assign accept    = if_valid && if_ready;
    assign deliver   = id_valid && id_ready;

    // Fields are plain slices so the zero-extend unit sees the held byte unchanged.
    assign id_instr  = instr_q;
    assign id_pc     = pc_q;
    assign id_opcode = instr_q[15:12];
    assign id_imm8   = instr_q[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            instr_q      <= 16'h0000;
            pc_q         <= '0;
`ifdef IF_ID_SKID_EN
            skid_instr_q <= 16'h0000;
            skid_pc_q    <= '0;
            rdy_q        <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
`ifdef IF_ID_SKID_EN
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            rdy_q        <= rdy_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
`ifdef IF_ID_SKID_EN
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
`endif
        // Flush only drops the valid state; data registers keep their contents.
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        instr_d = if_instr;
                        pc_d    = if_pc;
                    end
                end
                S_ONE: begin
`ifdef IF_ID_SKID_EN
                    if (accept && deliver) begin
                        instr_d = if_instr;
                        pc_d    = if_pc;
                    end else if (accept) begin
                        state_d      = S_FULL;
                        skid_instr_d = if_instr;
                        skid_pc_d    = if_pc;
                    end else if (deliver) begin
                        state_d = S_EMPTY;
                    end
`else
                    // Accept in ONE implies id_ready, so it is always a reload.
                    if (accept) begin
                        instr_d = if_instr;
                        pc_d    = if_pc;
                    end else if (deliver) begin
                        state_d = S_EMPTY;
                    end
`endif
                end
`ifdef IF_ID_SKID_EN
                S_FULL: begin
                    if (deliver) begin
                        state_d = S_ONE;
                        instr_d = skid_instr_q;
                        pc_d    = skid_pc_q;
                    end
                end
`endif
                default: state_d = S_EMPTY;
            endcase
        end
`ifdef IF_ID_SKID_EN
        rdy_d = (state_d != S_FULL);
`endif
    end

endmodule
